// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared state encoding, clog2 helper and default sizes for deadlock monitors.
package hls_deadlock_pkg;
   typedef enum logic [1:0] {IDLE, SUSPECT, DEADLOCK} state_t;
   localparam int DEF_N_AXIS    = 2;
   localparam int DEF_N_INST    = 1;
   localparam int DEF_N_SUB     = 1;
   localparam int DEF_THRESHOLD = 16;
   localparam int DEF_CNT_W     = 16;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/hls_deadlock_sat_counter.sv
// hls_deadlock_sat_counter: saturating up-counter with synchronous clear.
module hls_deadlock_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clock)
      if (reset || clr) count <= '0;
      else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/hls_deadlock_watchdog.sv
// hls_deadlock_watchdog: declares a sticky deadlock once the combined block condition persists
// THRESHOLD consecutive enabled cycles, with a cause snapshot and a saturating stall counter.
module hls_deadlock_watchdog
   import hls_deadlock_pkg::*;
#(
   parameter int N_AXIS    = DEF_N_AXIS,
   parameter int N_INST    = DEF_N_INST,
   parameter int N_SUB     = DEF_N_SUB,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            clear,
   input  logic [N_AXIS-1:0]               axis_block_sigs,
   input  logic [N_INST-1:0]               inst_idle_sigs,
   input  logic [N_INST-1:0]               inst_block_sigs,
   input  logic [N_SUB-1:0]                sub_block_sigs,
   output logic                            block,
   output logic                            deadlock,
   output logic                            deadlock_pulse,
   output logic [N_AXIS+N_INST+N_SUB-1:0]  cause,
   output logic [CNT_W-1:0]                stall_cycles
);
   localparam int PW = clog2(THRESHOLD) + 1;
   state_t state;
   logic [PW-1:0] pcnt;
   logic par_blk, cond, hit;
   // parallel instances stall only when every busy instance is blocked and at least one is
   assign par_blk = &(inst_block_sigs | inst_idle_sigs) & |inst_block_sigs;
   assign cond = |axis_block_sigs | |sub_block_sigs | par_blk;
   assign hit = enable && cond && (state == IDLE ? THRESHOLD == 1 :
                state == SUSPECT && pcnt == PW'(THRESHOLD - 1));
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         pcnt <= '0;
         block <= 1'b0;
         deadlock <= 1'b0;
         deadlock_pulse <= 1'b0;
         cause <= '0;
      end else begin
         block <= cond;
         deadlock_pulse <= 1'b0;
         if (clear) begin
            state <= IDLE;
            pcnt <= '0;
            deadlock <= 1'b0;
            cause <= '0;
         end else if (hit) begin
            state <= DEADLOCK;
            pcnt <= '0;
            deadlock <= 1'b1;
            deadlock_pulse <= 1'b1;
            cause <= {sub_block_sigs, inst_block_sigs, axis_block_sigs};
         end else if (state == IDLE && enable && cond) begin
            state <= SUSPECT;
            pcnt <= PW'(1);
         end else if (state == SUSPECT) begin
            if (enable && cond) pcnt <= pcnt + PW'(1);
            else begin
               state <= IDLE;
               pcnt <= '0;
            end
         end
      end
   end
   hls_deadlock_sat_counter #(.WIDTH(CNT_W)) u_stall (
      .clock(clock),
      .reset(reset),
      .inc(cond),
      .clr(clear),
      .count(stall_cycles)
   );
endmodule

// File: tb/tb_hls_deadlock_watchdog.sv
// tb_hls_deadlock_watchdog: two watchdog instances (THRESHOLD 16 / 1) checked every cycle
// against a run-length reference model, plus directed literal checks.
module tb_hls_deadlock_watchdog;
   logic clock = 1'b0, reset, enable, clear;
   logic [1:0] axis, idle, iblk;
   logic [0:0] sub;
   logic blk_a, dl_a, pls_a, blk_b, dl_b, pls_b;
   logic [4:0] cause_a, cause_b;
   logic [15:0] st_a;
   logic [3:0] st_b;
   int passed = 0, total = 0, np_a = 0;
   bit go = 1'b0;
   int thr[2] = '{16, 1};
   int smax[2] = '{65535, 15};
   int run[2], m_st[2];
   logic m_blk[2], m_dl[2], m_p[2];
   logic [4:0] m_cause[2];
   logic cnd;

   always #5 clock = ~clock;

   hls_deadlock_watchdog #(.N_AXIS(2), .N_INST(2), .N_SUB(1), .THRESHOLD(16), .CNT_W(16)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk), .sub_block_sigs(sub),
      .block(blk_a), .deadlock(dl_a), .deadlock_pulse(pls_a), .cause(cause_a), .stall_cycles(st_a));
   hls_deadlock_watchdog #(.N_AXIS(2), .N_INST(2), .N_SUB(1), .THRESHOLD(1), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk), .sub_block_sigs(sub),
      .block(blk_b), .deadlock(dl_b), .deadlock_pulse(pls_b), .cause(cause_b), .stall_cycles(st_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // reference: deadlock when the current run of enabled cond cycles reaches the threshold
   always @(posedge clock) begin
      cnd = (|axis) || sub[0] || ((&(iblk | idle)) && (|iblk));
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_blk[d] = 0; m_dl[d] = 0; m_p[d] = 0; m_cause[d] = 0; m_st[d] = 0; run[d] = 0;
         end else begin
            m_blk[d] = cnd;
            m_p[d] = 0;
            if (clear) begin
               m_dl[d] = 0; m_cause[d] = 0; m_st[d] = 0; run[d] = 0;
            end else begin
               if (cnd && m_st[d] < smax[d]) m_st[d]++;
               if (!m_dl[d]) begin
                  run[d] = (enable && cnd) ? run[d] + 1 : 0;
                  if (run[d] == thr[d]) begin
                     m_dl[d] = 1; m_p[d] = 1; m_cause[d] = {sub, iblk, axis}; run[d] = 0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (pls_a) np_a++;
      if (go) begin
         chk("a.block", 32'(blk_a), 32'(m_blk[0]));
         chk("a.deadlock", 32'(dl_a), 32'(m_dl[0]));
         chk("a.pulse", 32'(pls_a), 32'(m_p[0]));
         chk("a.cause", 32'(cause_a), 32'(m_cause[0]));
         chk("a.stall", 32'(st_a), 32'(m_st[0]));
         chk("b.block", 32'(blk_b), 32'(m_blk[1]));
         chk("b.deadlock", 32'(dl_b), 32'(m_dl[1]));
         chk("b.pulse", 32'(pls_b), 32'(m_p[1]));
         chk("b.cause", 32'(cause_b), 32'(m_cause[1]));
         chk("b.stall", 32'(st_b), 32'(m_st[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic clr_cycle();
      axis = 0; sub = 0; idle = 0; iblk = 0; clear = 1;
      cyc(1);
      clear = 0;
   endtask

   initial begin
      bit busy;
      reset = 1; enable = 0; clear = 0; axis = 0; idle = 0; iblk = 0; sub = 0;
      cyc(2);
      go = 1;
      chk("rst.deadlock", 32'(dl_a), 0);
      chk("rst.stall", 32'(st_a), 0);
      chk("rst.block", 32'(blk_a), 0);
      reset = 0; enable = 1; axis = 2'b01;
      cyc(1);
      chk("t1.block", 32'(blk_a), 1);
      cyc(14);
      chk("t1.dl_before", 32'(dl_a), 0);
      cyc(1);
      chk("t1.dl_16", 32'(dl_a), 1);
      chk("t1.pulse", 32'(pls_a), 1);
      cyc(4);
      chk("t1.pulse_count", 32'(np_a), 1);
      chk("t1.cause", 32'(cause_a), 32'h01);
      chk("t1.stall", 32'(st_a), 20);
      chk("t1.b_sat", 32'(st_b), 15);
      clr_cycle();
      axis = 2'b10; cyc(15); axis = 0; cyc(1); axis = 2'b10; cyc(15);
      chk("t2.no_dl", 32'(dl_a), 0);
      clr_cycle();
      idle = 2'b01; iblk = 2'b10; cyc(1);
      chk("t3.par_1", 32'(blk_a), 1);
      idle = 2'b00; iblk = 2'b10; cyc(1);
      chk("t3.par_0", 32'(blk_a), 0);
      idle = 2'b11; iblk = 2'b00; cyc(1);
      chk("t3.idle", 32'(blk_a), 0);
      idle = 2'b00; iblk = 2'b11; cyc(1);
      chk("t3.all_blk", 32'(blk_a), 1);
      clr_cycle();
      axis = 2'b01; cyc(20);
      chk("t4.dl", 32'(dl_a), 1);
      clear = 1; cyc(1); clear = 0;
      chk("t4.clr_dl", 32'(dl_a), 0);
      chk("t4.clr_cause", 32'(cause_a), 0);
      chk("t4.clr_stall", 32'(st_a), 0);
      cyc(15);
      chk("t4.dl_15", 32'(dl_a), 0);
      cyc(1);
      chk("t4.dl_16", 32'(dl_a), 1);
      chk("t4.pulses", 32'(np_a), 3);
      clr_cycle();
      enable = 0; axis = 2'b01; cyc(40);
      chk("t5.no_dl", 32'(dl_a), 0);
      chk("t5.stall", 32'(st_a), 40);
      chk("t5.b_sat", 32'(st_b), 15);
      chk("t5.b_no_dl", 32'(dl_b), 0);
      enable = 1;
      clr_cycle();
      axis = 2'b01; cyc(1); axis = 0;
      chk("t6.b_dl", 32'(dl_b), 1);
      chk("t6.b_pulse", 32'(pls_b), 1);
      chk("t6.a_no_dl", 32'(dl_a), 0);
      cyc(2);
      chk("t6.b_sticky", 32'(dl_b), 1);
      chk("t6.b_nopulse", 32'(pls_b), 0);
      reset = 1; cyc(1); reset = 0;
      chk("t6.rst_dl", 32'(dl_b), 0);
      chk("t6.rst_stall", 32'(st_b), 0);
      chk("t6.rst_cause", 32'(cause_b), 0);
      busy = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) busy = !busy;
         axis = busy ? 2'($urandom_range(1, 3)) : ($urandom_range(0, 9) == 0 ? 2'b01 : 2'b00);
         sub = 1'(busy && $urandom_range(0, 3) == 0);
         idle = 2'($urandom);
         iblk = busy ? 2'($urandom) : 2'b00;
         enable = $urandom_range(0, 15) != 0;
         clear = $urandom_range(0, 99) == 0;
         reset = $urandom_range(0, 499) == 0;
         cyc(1);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
